// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage definitions: exception cause codes, sequencer states, default vectors.
package mips_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EXT      = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } cause_e;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
    localparam int          DEF_INC          = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select: exception > eret > misaligned redirect > redirect > stall > sequential.
// Latency: combinational, no registers.
// Backpressure: stall only holds pc; every other request overrides it.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_next_seq,
    input  logic [WIDTH-1:0] epc,
    input  logic [1:0]       cause,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             eret,
    output logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] next_epc,
    output logic [1:0]       next_cause
);

    logic redir_misaligned;

    assign redir_misaligned = (redir_target[1:0] != 2'b00);

    always_comb begin
        next_pc    = pc_next_seq;
        next_epc   = epc;
        next_cause = cause;
        if (exc_req) begin
            next_pc    = EXC_VECTOR;
            next_epc   = exc_pc;
            next_cause = CAUSE_EXT;
        end else if (eret) begin
            next_pc    = epc;
            next_cause = CAUSE_NONE;
        end else if (redir_valid && redir_misaligned) begin
            // Bad target is trapped, never fetched; the handler sees it in epc.
            next_pc    = EXC_VECTOR;
            next_epc   = redir_target;
            next_cause = CAUSE_MISALIGN;
        end else if (redir_valid) begin
            next_pc    = redir_target;
        end else if (stall) begin
            next_pc    = pc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with redirect, exception entry and ERET, holding epc and cause.
// Latency: every request takes effect on the next edge; one BOOT bubble after reset.
// Backpressure: stall holds pc; redirects, exceptions and ERET override stall.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               INC          = DEF_INC
) (
    input  logic             clk,
    input  logic             clk_reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       cause
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [WIDTH-1:0] mux_pc;
    logic [WIDTH-1:0] mux_epc;
    logic [1:0]       mux_cause;

    assign pc_next_seq = pc + INC_W;

    pc_next_mux #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .pc           (pc),
        .pc_next_seq  (pc_next_seq),
        .epc          (epc),
        .cause        (cause),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .exc_req      (exc_req),
        .exc_pc       (exc_pc),
        .eret         (eret),
        .next_pc      (mux_pc),
        .next_epc     (mux_epc),
        .next_cause   (mux_cause)
    );

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fetch_valid = 1'b0;
        case (state)
            ST_BOOT: state_nxt   = ST_RUN;
            ST_RUN:  fetch_valid = 1'b1;
        endcase
    end

    // BOOT ignores all requests and just (re)loads the reset vector.
    always_ff @(posedge clk) begin
        if (clk_reset) begin
            pc    <= RESET_VECTOR;
            epc   <= '0;
            cause <= CAUSE_NONE;
        end else if (state == ST_BOOT) begin
            pc    <= RESET_VECTOR;
        end else begin
            pc    <= mux_pc;
            epc   <= mux_epc;
            cause <= mux_cause;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] EV  = 32'h0000_0080;
    localparam logic [31:0] INC = 32'd4;

    logic        clk = 1'b0;
    logic        clk_reset;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        fetch_valid;
    logic [31:0] epc;
    logic [1:0]  cause;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    bit          m_boot;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .clk_reset    (clk_reset),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .exc_req      (exc_req),
        .exc_pc       (exc_pc),
        .eret         (eret),
        .pc           (pc),
        .pc_next_seq  (pc_next_seq),
        .fetch_valid  (fetch_valid),
        .epc          (epc),
        .cause        (cause)
    );

    task automatic idle();
        clk_reset    = 1'b0;
        stall        = 1'b0;
        redir_valid  = 1'b0;
        redir_target = 32'h0;
        exc_req      = 1'b0;
        exc_pc       = 32'h0;
        eret         = 1'b0;
    endtask

    // One rising edge; the model applies the documented rules to the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (clk_reset) begin
            m_boot = 1'b1; m_pc = RV; m_epc = 32'h0; m_cause = 2'd0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_pc = RV;
        end else if (exc_req) begin
            m_pc = EV; m_epc = exc_pc; m_cause = 2'd1;
        end else if (eret) begin
            m_pc = m_epc; m_cause = 2'd0;
        end else if (redir_valid && (redir_target % 4 != 0)) begin
            m_pc = EV; m_epc = redir_target; m_cause = 2'd2;
        end else if (redir_valid) begin
            m_pc = redir_target;
        end else if (!stall) begin
            m_pc = m_pc + INC;
        end
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        idle();
        redir_valid = 1'b1; redir_target = target;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        clk_reset = 1'b1;
        tick(); tick();
        checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", epc); end
        checks++; if (cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", cause); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
        clk_reset = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_fv: got %b want 0", fetch_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pc !== 32'(i * 4) || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL run_seq[%0d]: pc=%h fv=%b want pc=%h fv=1", i, pc, fetch_valid, 32'(i * 4));
            end
        end
        checks++; if (pc_next_seq !== 32'h10) begin errors++; $display("FAIL next_seq: got %h want 00000010", pc_next_seq); end
    endtask

    task automatic test_stall_redirect();
        goto_pc(32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold[%0d]: pc=%h want 00000010", i, pc); end
            tick();
        end
        redir_valid = 1'b1; redir_target = 32'h200;
        tick();
        idle();
        checks++;
        if (pc !== 32'h200 || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL stall_redirect: pc=%h fv=%b want 00000200 fv=1", pc, fetch_valid);
        end
    endtask

    task automatic test_exception();
        goto_pc(32'h40);
        exc_req = 1'b1; exc_pc = 32'h3C;
        tick();
        idle();
        checks++;
        if (pc !== EV || epc !== 32'h3C || cause !== 2'd1 || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL exc_entry: pc=%h epc=%h cause=%0d fv=%b want 00000080/0000003c/1/1", pc, epc, cause, fetch_valid);
        end
        tick();
        checks++; if (pc !== 32'h84) begin errors++; $display("FAIL handler_adv: pc=%h want 00000084", pc); end
        eret = 1'b1;
        tick();
        idle();
        checks++;
        if (pc !== 32'h3C || cause !== 2'd0 || epc !== 32'h3C) begin
            errors++; $display("FAIL eret: pc=%h cause=%0d epc=%h want 0000003c/0/0000003c", pc, cause, epc);
        end
    endtask

    task automatic test_misaligned();
        goto_pc(32'h102);
        checks++;
        if (pc !== EV || epc !== 32'h102 || cause !== 2'd2) begin
            errors++; $display("FAIL misaligned: pc=%h epc=%h cause=%0d want 00000080/00000102/2", pc, epc, cause);
        end
    endtask

    task automatic test_simultaneous();
        goto_pc(32'h500);
        exc_req = 1'b1; exc_pc = 32'h1234; eret = 1'b1; stall = 1'b1;
        redir_valid = 1'b1; redir_target = 32'h300;
        tick();
        idle();
        checks++;
        if (pc !== EV || epc !== 32'h1234 || cause !== 2'd1) begin
            errors++; $display("FAIL simultaneous: pc=%h epc=%h cause=%0d want 00000080/00001234/1", pc, epc, cause);
        end
    endtask

    task automatic test_back_to_back();
        goto_pc(32'h600);
        exc_req = 1'b1; exc_pc = 32'h5A0;
        tick();
        idle();
        eret = 1'b1;
        tick();
        idle();
        checks++;
        if (pc !== 32'h5A0 || cause !== 2'd0) begin
            errors++; $display("FAIL eret_after_exc: pc=%h cause=%0d want 000005a0/0", pc, cause);
        end
    endtask

    task automatic test_wrap_reset();
        goto_pc(32'hFFFF_FFFC);
        checks++;
        if (pc_next_seq !== 32'h0) begin errors++; $display("FAIL wrap_next_seq: got %h want 00000000", pc_next_seq); end
        tick();
        checks++;
        if (pc !== 32'h0 || cause !== 2'd0) begin errors++; $display("FAIL wrap: pc=%h cause=%0d want 00000000/0", pc, cause); end
        exc_req = 1'b1; exc_pc = 32'hABC0;
        tick();
        idle();
        stall = 1'b1;
        tick();
        clk_reset = 1'b1;
        tick();
        clk_reset = 1'b0;
        #1;
        checks++;
        if (pc !== RV || epc !== 32'h0 || cause !== 2'd0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL midrun_reset: pc=%h epc=%h cause=%0d fv=%b want 0/0/0/0", pc, epc, cause, fetch_valid);
        end
        // BOOT must ignore requests.
        exc_req = 1'b1; exc_pc = 32'h77C; redir_valid = 1'b1; redir_target = 32'h900;
        tick();
        idle();
        checks++;
        if (pc !== RV || fetch_valid !== 1'b1 || cause !== 2'd0) begin
            errors++; $display("FAIL boot_ignore: pc=%h fv=%b cause=%0d want 0/1/0", pc, fetch_valid, cause);
        end
        tick();
        checks++; if (pc !== RV + INC) begin errors++; $display("FAIL post_reset_adv: pc=%h want 00000004", pc); end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 400; n++) begin
            idle();
            r = $urandom_range(0, 99);
            clk_reset   = (r < 2);
            stall       = ($urandom_range(0, 3) == 0);
            exc_req     = ($urandom_range(0, 9) == 0);
            eret        = ($urandom_range(0, 7) == 0);
            redir_valid = ($urandom_range(0, 4) == 0);
            exc_pc      = $urandom;
            case ($urandom_range(0, 3))
                0:       redir_target = $urandom;
                1:       redir_target = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                default: redir_target = $urandom & 32'h0000_FFFC;
            endcase
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
            checks++; if (epc !== m_epc) begin errors++; $display("FAIL rnd_epc[%0d]: got %h want %h", n, epc, m_epc); end
            checks++; if (cause !== m_cause) begin errors++; $display("FAIL rnd_cause[%0d]: got %0d want %0d", n, cause, m_cause); end
            checks++; if (fetch_valid !== !m_boot) begin errors++; $display("FAIL rnd_fv[%0d]: got %b want %b", n, fetch_valid, !m_boot); end
            checks++; if (pc_next_seq !== m_pc + INC) begin errors++; $display("FAIL rnd_next_seq[%0d]: got %h want %h", n, pc_next_seq, m_pc + INC); end
        end
        idle();
    endtask

    initial begin
        m_pc = RV; m_epc = 32'h0; m_cause = 2'd0; m_boot = 1'b1;
        idle();
        clk_reset = 1'b1;
        test_reset();
        test_stall_redirect();
        test_exception();
        test_misaligned();
        test_simultaneous();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS fetch stage, the next-generation replacement for the plain PC register. It holds the fetch address and advances it by a fixed increment. It accepts branch/jump redirects, exception entry and exception return (ERET) with an internal EPC. Illegal or misaligned targets become a defined address-error exception; undefined inputs never silently reset the PC. It feeds the instruction memory address and the IF/ID pipeline register.

## Interface
Parameters:
- WIDTH, 32, PC/address width (≥ 8)
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (word aligned)
- EXC_VECTOR, 32'h0000_0080, exception handler entry (word aligned)
- INC, 4, sequential increment in bytes

Ports:
- clk  in  1  clock, all state updates on rising edge
- clk_reset  in  1  reset, synchronous, active-high
- stall  in  1  hold current PC (hazard unit)
- redir_valid  in  1  branch/jump taken this cycle
- redir_target  in  WIDTH  redirect address
- exc_req  in  1  exception raised by a later stage
- exc_pc  in  WIDTH  PC of faulting instruction, saved into EPC
- eret  in  1  return from exception
- pc  out  WIDTH  current fetch address
- pc_next_seq  out  WIDTH  pc + INC (combinational, mod 2^WIDTH)
- fetch_valid  out  1  pc is a real fetch this cycle
- epc  out  WIDTH  exception program counter
- cause  out  2  last exception cause: 0 none, 1 external, 2 misaligned fetch

## Operation
- FSM: BOOT, RUN.
  - BOOT: entered on reset; fetch_valid=0; next cycle unconditionally goes to RUN with pc=RESET_VECTOR.
  - RUN: fetch_valid=1.
- Next-PC priority in RUN, highest first:
  1. exc_req: pc<=EXC_VECTOR, epc<=exc_pc, cause<=1.
  2. eret: pc<=epc, cause<=0.
  3. redir_valid with redir_target[1:0]≠0: pc<=EXC_VECTOR, epc<=redir_target, cause<=2.
  4. redir_valid, aligned: pc<=redir_target.
  5. stall: pc holds.
  6. Otherwise: pc<=pc+INC.
- Exceptions, ERET and redirects override stall.
- Simultaneous exc_req and eret: exc_req wins, and epc takes exc_pc.
- Inputs in BOOT are ignored.
- Wrap-around: pc+INC at the top of the address space wraps to 0 without error.
- No X-detection on inputs; every input combination has the defined response above.

## Timing
- Reset values: pc=RESET_VECTOR, epc=0, cause=0, fetch_valid=0, state=BOOT.
- pc_next_seq follows pc combinationally.
- Reset asserted mid-operation overrides every other input on that edge.
- After reset deasserts: one BOOT cycle, then fetch_valid=1 from the following cycle.
- Redirect, exception and ERET latency is 1 cycle: the new pc is visible the cycle after the request, with no bubble and fetch_valid staying 1.
- epc and cause update on the same edge as pc.
- An ERET in the cycle right after exception entry returns to the just-written epc.

## Structure
- Shared package mips_pkg holds:
  - cause encodings CAUSE_NONE/CAUSE_EXT/CAUSE_MISALIGN
  - FSM state enum
  - default vector constants
- One natural sub-module: pc_next_mux, the combinational priority select of the next-PC source. The register file for pc/epc/cause and the FSM stay in pc_sequencer.
- Expected size: about 150–250 lines.

## Test plan
- Reset then run:
  - Stimulus: clk_reset high 2 cycles, then low; no other inputs.
  - Required: fetch_valid=0 for the BOOT cycle, then pc sequence 0x0, 0x4, 0x8, 0xC with fetch_valid=1.
- Stall vs. redirect:
  - Stimulus: stall high 3 cycles at pc=0x10, then stall+redir_valid with target 0x200.
  - Required: pc holds 0x10 for 3 cycles, then becomes 0x200 on the next cycle.
- Exception and return:
  - Stimulus: at pc=0x40, exc_req=1 with exc_pc=0x3C; later eret=1.
  - Required: pc=0x80, epc=0x3C, cause=1; after eret, pc=0x3C and cause=0.
- Misaligned redirect:
  - Stimulus: redir_valid with target 0x102.
  - Required: pc=0x80, epc=0x102, cause=2.
- Simultaneous events:
  - Stimulus: exc_req, eret and redir_valid all asserted in one cycle.
  - Required: exception path only (pc=EXC_VECTOR, epc=exc_pc).
- Wrap and mid-run reset:
  - Stimulus: redirect to 0xFFFF_FFFC, then one advance; afterwards clk_reset pulsed during a stall.
  - Required: pc advances to 0x0000_0000; on the reset pulse pc=RESET_VECTOR and epc=0, with one BOOT cycle before fetching resumes.
